// File: rtl/uart_tx_mmio_if.sv
// CPU data-bus view of the memory-mapped UART transmitter.
// dout carries the CPU's read data (its "di" input); "do" is a reserved word.
interface uart_tx_mmio_if;
    logic [15:0] addr;
    logic [7:0]  di;
    logic        we;
    logic [7:0]  dout;
    logic        hit;

    modport master (
        output addr,
        output di,
        output we,
        input  dout,
        input  hit
    );

    modport slave (
        input  addr,
        input  di,
        input  we,
        output dout,
        output hit
    );
endinterface

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: a TXDATA/STATUS register pair in front of a
// small byte FIFO that drains into a registered serial tx line.
module uart_tx_mmio #(
    parameter logic [15:0] BASE_ADDR    = 16'hFF00,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    uart_tx_mmio_if.slave        bus,
    output logic                 tx
);

    localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST   = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  DEPTH_CNT   = CNT_W'(FIFO_DEPTH);
    localparam logic [15:0]       STATUS_ADDR = BASE_ADDR + 16'd1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    typedef struct packed {
        logic [3:0] count;
        logic       overflow;
        logic       empty;
        logic       full;
        logic       busy;
    } status_t;

    state_t              state_q;
    state_t              state_d;
    logic [BAUD_W-1:0]   baud_q;
    logic [2:0]          bit_q;
    logic [7:0]          shift_q;
    logic                tx_q;
    logic                tx_d;

    logic [7:0]          mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q;
    logic [PTR_W-1:0]    rd_ptr_q;
    logic [CNT_W-1:0]    count_q;
    logic                overflow_q;

    logic                sel_data;
    logic                sel_status;
    logic                push_req;
    logic                push;
    logic                pop;
    logic                fifo_empty;
    logic                baud_done;
    logic [4:0]          cnt_ext;
    status_t             status;

    // Address decode and write qualification
    assign sel_data   = (bus.addr == BASE_ADDR);
    assign sel_status = (bus.addr == STATUS_ADDR);
    assign push_req   = bus.we && sel_data;
    assign fifo_empty = (count_q == '0);
    assign baud_done  = (baud_q == BAUD_LAST);

    // A full FIFO still takes a byte when the head leaves on the same edge
    assign push = push_req && ((count_q < DEPTH_CNT) || pop);

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d = START;
                end
            end
            START: begin
                if (baud_done) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (baud_done && (bit_q == 3'd7)) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (baud_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode: line level for the next cycle and FIFO pop request
    always_comb begin
        tx_d = 1'b1;
        pop  = 1'b0;
        case (state_q)
            IDLE:    pop  = !fifo_empty;
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_q[0];
            STOP:    tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase
    end

    // Serialiser datapath: baud timer, bit index, shift register, tx flop
    always_ff @(posedge clk) begin
        if (!rst) begin
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            tx_q <= tx_d;
            if ((state_q == IDLE) || baud_done) begin
                baud_q <= '0;
            end else begin
                baud_q <= baud_q + BAUD_W'(1);
            end
            if (pop) begin
                shift_q <= mem[rd_ptr_q];
                bit_q   <= '0;
            end else if ((state_q == DATA) && baud_done) begin
                shift_q <= {1'b0, shift_q[7:1]};
                bit_q   <= bit_q + 3'd1;
            end
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
            if (push_req && !push) begin
                overflow_q <= 1'b1;
            end else if (bus.we && sel_status) begin
                overflow_q <= 1'b0;
            end
        end
    end

    // FIFO storage; stale entries are unreachable once the pointers reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= bus.di;
        end
    end

    // STATUS word; the count field saturates at 15
    always_comb begin
        cnt_ext         = 5'(count_q);
        status.count    = cnt_ext[4] ? 4'hF : cnt_ext[3:0];
        status.overflow = overflow_q;
        status.empty    = fifo_empty;
        status.full     = (count_q == DEPTH_CNT);
        status.busy     = (state_q != IDLE);
    end

    assign bus.dout = sel_status ? status : 8'h00;
    assign bus.hit  = sel_data || sel_status;
    assign tx       = tx_q;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Randomised bench for uart_tx_mmio against a frame-timeline reference model.
module tb_uart_tx_mmio;

    localparam int unsigned C     = 4;
    localparam int unsigned DEPTH = 8;
    localparam logic [15:0] BASE  = 16'hFF00;
    localparam logic [15:0] STAT  = 16'hFF01;

    logic clk;
    logic rst;
    logic tx;

    uart_tx_mmio_if bus ();

    uart_tx_mmio #(
        .BASE_ADDR    (BASE),
        .CLKS_PER_BIT (C),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .tx  (tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: queued bytes, sticky overflow, and the frame in flight
    logic [7:0] q [$];
    bit         ovf        = 1'b0;
    bit         have_frame = 1'b0;
    bit         known      = 1'b0;
    logic [7:0] cur_byte   = 8'h00;
    int         t0         = 0;
    int         last_edge  = -1;

    int a5_seq [10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, last_edge);
        end
    endtask

    function automatic logic [7:0] model_status();
        int cnt;
        logic busy;
        cnt  = q.size();
        busy = have_frame && ((last_edge - t0) < 10 * C);
        return {4'((cnt > 15) ? 15 : cnt), ovf, (cnt == 0), (cnt == DEPTH), busy};
    endfunction

    // Line level after the most recent edge: frame bits start one edge after the pop
    function automatic logic model_tx();
        int k;
        if (!have_frame) return 1'b1;
        k = last_edge - t0;
        if (k < 1 || k > 10 * C) return 1'b1;
        k = (k - 1) / C;
        if (k == 0) return 1'b0;
        if (k <= 8) return cur_byte[k-1];
        return 1'b1;
    endfunction

    task automatic model_edge(input logic r, input logic w, input logic [15:0] a, input logic [7:0] d);
        int n;
        bit idle;
        n = last_edge + 1;
        if (!r) begin
            q.delete();
            ovf        = 1'b0;
            have_frame = 1'b0;
            known      = 1'b1;
        end else begin
            idle = !(have_frame && ((n - 1 - t0) < 10 * C));
            if (idle && q.size() > 0) begin
                cur_byte   = q.pop_front();
                t0         = n;
                have_frame = 1'b1;
            end
            if (w && a == BASE) begin
                if (q.size() < DEPTH) q.push_back(d);
                else ovf = 1'b1;
            end
            if (w && a == STAT) ovf = 1'b0;
        end
        last_edge = n;
    endtask

    // One clock: drive, check combinational read path, clock, check tx
    task automatic step(input logic r, input logic w, input logic [15:0] a, input logic [7:0] d);
        rst      = r;
        bus.we   = w;
        bus.addr = a;
        bus.di   = d;
        #1;
        if (known) begin
            check("do", bus.dout, (a == STAT) ? model_status() : 8'h00);
            check("hit", bus.hit, (a == BASE) || (a == STAT));
        end
        @(posedge clk);
        model_edge(r, w, a, d);
        #1;
        if (known) check("tx", tx, model_tx());
    endtask

    initial begin
        int sel;
        logic r, w;
        logic [15:0] a;

        rst      = 1'b0;
        bus.we   = 1'b0;
        bus.addr = STAT;
        bus.di   = 8'h00;

        step(1'b0, 1'b0, STAT, 8'h00);
        step(1'b0, 1'b0, STAT, 8'h00);
        check("reset_status", bus.dout, 8'h04);
        check("reset_tx", tx, 1'b1);
        repeat (3) step(1'b1, 1'b0, STAT, 8'h00);

        // Single byte A5 framed LSB first
        step(1'b1, 1'b1, BASE, 8'hA5);
        step(1'b1, 1'b0, STAT, 8'h00);
        check("busy_after_write", bus.dout[0], 1'b1);
        for (int k = 0; k < 40; k++) begin
            step(1'b1, 1'b0, STAT, 8'h00);
            if (k % 4 == 1) check("a5_bit", tx, a5_seq[k/4]);
        end
        check("a5_done_status", bus.dout, 8'h04);

        // Burst of ten writes into an idle transmitter
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, BASE, 8'(i));
        bus.we   = 1'b0;
        bus.addr = STAT;
        #1;
        check("burst_status", bus.dout, 8'h8B);
        step(1'b1, 1'b1, STAT, 8'h00);
        check("ovf_clear", bus.dout, 8'h83);
        repeat (400) step(1'b1, 1'b0, STAT, 8'h00);
        check("drained_status", bus.dout, 8'h04);

        // Reset in the middle of a data bit with bytes still queued
        step(1'b1, 1'b1, BASE, 8'h11);
        step(1'b1, 1'b1, BASE, 8'h22);
        step(1'b1, 1'b1, BASE, 8'h33);
        repeat (14) step(1'b1, 1'b0, STAT, 8'h00);
        step(1'b0, 1'b0, STAT, 8'h00);
        check("midframe_rst_status", bus.dout, 8'h04);
        check("midframe_rst_tx", tx, 1'b1);
        repeat (60) step(1'b1, 1'b0, STAT, 8'h00);

        // Address window decode
        bus.we   = 1'b0;
        bus.addr = BASE;
        #1;
        check("rd_ff00_do", bus.dout, 8'h00);
        check("rd_ff00_hit", bus.hit, 1'b1);
        bus.addr = 16'hFF02;
        #1;
        check("rd_ff02_do", bus.dout, 8'h00);
        check("rd_ff02_hit", bus.hit, 1'b0);
        bus.addr = 16'h0003;
        #1;
        check("rd_0003_do", bus.dout, 8'h00);
        check("rd_0003_hit", bus.hit, 1'b0);
        bus.addr = STAT;
        #1;
        check("rd_ff01_hit", bus.hit, 1'b1);
        step(1'b1, 1'b1, 16'h0003, 8'h55);
        step(1'b1, 1'b0, STAT, 8'h00);
        check("outside_write_status", bus.dout, 8'h04);

        // Random traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            r   = ($urandom_range(0, 399) != 0);
            w   = ($urandom_range(0, 3) == 0);
            sel = $urandom_range(0, 9);
            if (sel < 5)       a = BASE;
            else if (sel < 8)  a = STAT;
            else if (sel == 8) a = 16'hFF02;
            else               a = 16'($urandom);
            step(r, w, a, 8'($urandom));
        end
        repeat (500) step(1'b1, 1'b0, STAT, 8'h00);
        check("final_status", bus.dout, 8'h04);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
